sd_spi_cmd_host: RTL and testbench
==================================

# sd_spi_cmd_host

Host-side SD command engine for SPI mode. It is the initiator counterpart of the bench SD card responder. It accepts a command index and argument from the init/control FSM, then serialises the 48-bit frame with CRC7 on MOSI. It waits for the card's R1 or R7 response on MISO, captures it, appends the Nrc trailing clocks, and returns the result or a timeout. It sits between `sd_initial`-style sequencers and the SD pins.

## Interface
Parameters:
- `CLK_DIV`, default 2: `clk` cycles per `sd_clk` half-period; must be ≥1.
- `NCR_MAX`, default 8: response wait limit in bytes; timeout after `NCR_MAX*8` `sd_clk` rising edges with no start bit.
- `NRC_CLKS`, default 8: trailing `sd_clk` cycles with MOSI=1 after the response.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  engine idle; accept when `cmd_valid && cmd_ready`
- `cmd_idx`  in  6  command index
- `cmd_arg`  in  32  command argument
- `resp_long`  in  1  0: R1 (8 bits); 1: R7 (40 bits); sampled at accept
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_data`  out  40  captured response, right-aligned; R1 is in [7:0] with [39:8]=0
- `rsp_timeout`  out  1  valid with `rsp_valid`; 1 means no start bit was seen
- `sd_clk`  out  1  SPI clock, idle low
- `sd_cs_n`  out  1  chip select
- `sd_mosi`  out  1  host to card
- `sd_miso`  in  1  card to host

## Operation
- Frame is {0, 1, `cmd_idx`, `cmd_arg`, crc7, 1}, transmitted MSB first.
  - crc7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
  - Index, argument and `resp_long` are latched at accept.
- States:
  - **IDLE**
    - `cmd_ready`=1, `sd_cs_n`=1, `sd_mosi`=1, `sd_clk`=0.
    - On accept: `sd_cs_n`=0, `sd_mosi`=frame[47], `bit_cnt`=47, go to SEND.
  - **SEND**
    - `sd_clk` toggles every `CLK_DIV` cycles.
    - On each falling edge: if `bit_cnt`>0, drive frame[`bit_cnt`-1] and decrement.
    - After the falling edge that ends bit 0: `sd_mosi`=1, `wait_cnt`=`NCR_MAX*8`, go to WAIT_RSP.
  - **WAIT_RSP**
    - On each rising edge, sample `sd_miso`.
    - If 0: this bit is response MSB; load it into the shift register, `rx_cnt`=N-1 (N=8 or 40), go to RECV (or TRAIL if N-1=0; not reachable).
    - Otherwise decrement `wait_cnt`. When it reaches 0, set the timeout flag, set `rsp_data`=all ones, go to TRAIL.
  - **RECV**
    - On each rising edge, shift `sd_miso` in LSB-side and decrement `rx_cnt`.
    - When `rx_cnt` reaches 0, latch `rsp_data`, go to TRAIL.
  - **TRAIL**
    - `NRC_CLKS` full `sd_clk` cycles with `sd_mosi`=1, `sd_cs_n`=0.
    - After the last falling edge: `sd_cs_n`=1, pulse `rsp_valid`, go to IDLE.
- `cmd_valid` while not ready is ignored; there is no queueing and no abort.
- MISO is ignored outside WAIT_RSP/RECV.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_timeout`=0, `sd_clk`=0, `sd_cs_n`=1, `sd_mosi`=1.
- Reset mid-operation returns to IDLE immediately (asynchronously); the partial frame is discarded.
- `sd_clk` edges:
  - Rising edge `CLK_DIV` cycles after accept, then alternating every `CLK_DIV` cycles.
  - MOSI changes only on falling edges; MISO is sampled on rising edges (SPI mode 0).
- Latency:
  - Accept to `rsp_valid` = (48 + W + N + `NRC_CLKS`)·2·`CLK_DIV` + 1 clk.
  - W is the number of all-ones rising edges before the start bit.
  - On timeout, W=`NCR_MAX*8` and N=0.
- A start bit on edge `NCR_MAX*8` is accepted; the timeout fires only after that edge samples 1.
- `rsp_timeout` and `rsp_data` hold their values until the next `rsp_valid`.
- `cmd_ready` rises in the same cycle as `rsp_valid`. A new command may be accepted in that cycle.

## Structure
- Package `sd_pkg` holds:
  - State enum.
  - `SD_FRAME_W`=48, `SD_R1_W`=8, `SD_R7_W`=40.
  - CRC7 polynomial `7'h09`.
  - Command constants `CMD0`=0, `CMD8`=8, `CMD55`=55, `ACMD41`=41.
- Sub-module `sd_crc7`: combinational CRC7 over 40 bits; also reused by the bench responder's checker.
- Clock-divider counter and edge strobes live inline in the top module.

## Test plan
- CMD0, arg 0, R1:
  - MOSI bytes must be 40 00 00 00 00 95.
  - Card returns 0x01 after 2 idle bytes → `rsp_data`=0x01, `rsp_timeout`=0.
- CMD8, arg 0x1AA, `resp_long`=1:
  - MOSI bytes must be 48 00 00 01 AA 87.
  - Card returns 01 00 00 01 AA → `rsp_data`=0x01000001AA.
- CMD55 arg 0 → MOSI 77 00 00 00 00 65. ACMD41 arg 0x40000000 → MOSI 69 40 00 00 00 77. R1 0x00 → `rsp_data`=0.
- MISO held 1:
  - `rsp_valid` with `rsp_timeout`=1 and `rsp_data`=all ones after exactly 64 wait edges (default `NCR_MAX`).
  - A start bit on edge 64 in a repeat run yields a normal response.
- `cmd_valid` held high through a transaction:
  - Exactly one accept while busy.
  - Second accept in the `rsp_valid` cycle.
  - `sd_cs_n` high for exactly that one cycle.
- `rst_n` asserted mid-SEND (bit 20): outputs take reset values the same cycle; the next command's frame is correct.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    RECV,
    TRAIL
  } sd_state_e;

  localparam int SD_FRAME_W = 48;
  localparam int SD_R1_W    = 8;
  localparam int SD_R7_W    = 40;

  // x^7 + x^3 + 1
  localparam logic [6:0] SD_CRC7_POLY = 7'h09;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

endpackage

// File: rtl/sd_spi_cmd_host_if.sv
// Command/response bus between an init sequencer (master) and the SD command engine (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready on the command side; the response is a one-cycle pulse with no ready.
// Signals: cmd_valid/cmd_ready handshake, cmd_idx, cmd_arg, resp_long (R7 when 1),
//          rsp_valid pulse, rsp_data (right-aligned), rsp_timeout.
interface sd_spi_cmd_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        resp_long;
  logic        rsp_valid;
  logic [39:0] rsp_data;
  logic        rsp_timeout;

  modport master (
    output cmd_valid, cmd_idx, cmd_arg, resp_long,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_idx, cmd_arg, resp_long,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7+x^3+1, init 0) over the first 40 bits of an SD command frame.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: data_i = {start, transmit, index, argument} MSB first; crc_o = 7-bit CRC.
module sd_crc7
  import sd_pkg::*;
(
  input  logic [39:0] data_i,
  output logic [6:0]  crc_o
);

  always_comb begin
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    fb  = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data_i[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    end
    crc_o = crc;
  end

endmodule

// File: rtl/sd_spi_cmd_host.sv
// SD SPI-mode command engine: sends a 48-bit command frame, captures R1/R7 or times out, adds Nrc clocks.
// Latency: accept to rsp_valid = (48 + W + N + NRC_CLKS) * 2 * CLK_DIV + 1 clk.
// Backpressure: cmd_ready is low for the whole transaction; rsp_valid is a pulse with no ready.
// Ports: clk, rst_n (async, active-low), cmd_bus (slave side of sd_spi_cmd_host_if),
//        sd_clk / sd_cs_n / sd_mosi to the card, sd_miso from the card. All outputs are registered.
module sd_spi_cmd_host
  import sd_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int NCR_MAX  = 8,
  parameter int NRC_CLKS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sd_spi_cmd_host_if.slave        cmd_bus,
  output logic                    sd_clk,
  output logic                    sd_cs_n,
  output logic                    sd_mosi,
  input  logic                    sd_miso
);

  localparam int              DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]     WAIT_INIT  = 16'(NCR_MAX * 8);
  localparam logic [15:0]     TRAIL_INIT = 16'(NRC_CLKS);

  sd_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sd_clk_q, sd_clk_d;
  logic             sd_cs_n_q, sd_cs_n_d;
  logic             sd_mosi_q, sd_mosi_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [5:0]       rx_cnt_q, rx_cnt_d;
  logic [15:0]      trail_cnt_q, trail_cnt_d;
  logic [39:0]      shift_q, shift_d;
  logic             to_pend_q, to_pend_d;
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      arg_q, arg_d;
  logic             long_q, long_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [39:0]      rsp_data_q, rsp_data_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  logic             sck_rise, sck_fall;
  logic [6:0]       crc;
  logic [47:0]      frame;

  sd_crc7 u_crc7 (
    .data_i ({2'b01, idx_q, arg_q}),
    .crc_o  (crc)
  );

  assign frame = {2'b01, idx_q, arg_q, crc, 1'b1};

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    sd_clk_d      = sd_clk_q;
    sd_cs_n_d     = sd_cs_n_q;
    sd_mosi_d     = sd_mosi_q;
    bit_cnt_d     = bit_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    rx_cnt_d      = rx_cnt_q;
    trail_cnt_d   = trail_cnt_q;
    shift_d       = shift_q;
    to_pend_d     = to_pend_q;
    idx_d         = idx_q;
    arg_d         = arg_q;
    long_d        = long_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    sck_rise      = 1'b0;
    sck_fall      = 1'b0;

    // Divider free-runs only while a transaction is active; it is zero on entry.
    if (state_q != IDLE) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        sd_clk_d = ~sd_clk_q;
        sck_rise = ~sd_clk_q;
        sck_fall = sd_clk_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_bus.cmd_valid && cmd_ready_q) begin
          idx_d       = cmd_bus.cmd_idx;
          arg_d       = cmd_bus.cmd_arg;
          long_d      = cmd_bus.resp_long;
          sd_cs_n_d   = 1'b0;
          sd_mosi_d   = 1'b0;  // frame[47], the start bit, is always 0
          bit_cnt_d   = 6'(SD_FRAME_W - 1);
          div_d       = '0;
          sd_clk_d    = 1'b0;
          shift_d     = '0;
          to_pend_d   = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (sck_fall) begin
          if (bit_cnt_q != 6'd0) begin
            sd_mosi_d = frame[bit_cnt_q - 6'd1];
            bit_cnt_d = bit_cnt_q - 6'd1;
          end else begin
            sd_mosi_d  = 1'b1;
            wait_cnt_d = WAIT_INIT;
            state_d    = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (sck_rise) begin
          // Start bit is checked before the budget so the last allowed edge still counts.
          if (!sd_miso) begin
            shift_d  = '0;
            rx_cnt_d = long_q ? 6'(SD_R7_W - 1) : 6'(SD_R1_W - 1);
            state_d  = RECV;
          end else if (wait_cnt_q == 16'd1) begin
            shift_d     = '1;
            to_pend_d   = 1'b1;
            trail_cnt_d = TRAIL_INIT;
            state_d     = TRAIL;
          end else begin
            wait_cnt_d = wait_cnt_q - 16'd1;
          end
        end
      end
      RECV: begin
        if (sck_rise) begin
          shift_d  = {shift_q[38:0], sd_miso};
          rx_cnt_d = rx_cnt_q - 6'd1;
          if (rx_cnt_q == 6'd1) begin
            trail_cnt_d = TRAIL_INIT;
            state_d     = TRAIL;
          end
        end
      end
      TRAIL: begin
        // The first fall closes the response bit's clock; NRC_CLKS more full clocks follow.
        if (sck_fall) begin
          if (trail_cnt_q == 16'd0) begin
            sd_cs_n_d     = 1'b1;
            rsp_valid_d   = 1'b1;
            rsp_data_d    = shift_q;
            rsp_timeout_d = to_pend_q;
            cmd_ready_d   = 1'b1;
            state_d       = IDLE;
          end else begin
            trail_cnt_d = trail_cnt_q - 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_q         <= '0;
      sd_clk_q      <= 1'b0;
      sd_cs_n_q     <= 1'b1;
      sd_mosi_q     <= 1'b1;
      bit_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      rx_cnt_q      <= '0;
      trail_cnt_q   <= '0;
      shift_q       <= '0;
      to_pend_q     <= 1'b0;
      idx_q         <= '0;
      arg_q         <= '0;
      long_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      sd_clk_q      <= sd_clk_d;
      sd_cs_n_q     <= sd_cs_n_d;
      sd_mosi_q     <= sd_mosi_d;
      bit_cnt_q     <= bit_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      trail_cnt_q   <= trail_cnt_d;
      shift_q       <= shift_d;
      to_pend_q     <= to_pend_d;
      idx_q         <= idx_d;
      arg_q         <= arg_d;
      long_q        <= long_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_bus.cmd_ready   = cmd_ready_q;
  assign cmd_bus.rsp_valid   = rsp_valid_q;
  assign cmd_bus.rsp_data    = rsp_data_q;
  assign cmd_bus.rsp_timeout = rsp_timeout_q;
  assign sd_clk              = sd_clk_q;
  assign sd_cs_n             = sd_cs_n_q;
  assign sd_mosi             = sd_mosi_q;

endmodule

// File: tb/tb_sd_spi_cmd_host.sv
// Bench for sd_spi_cmd_host: a scripted SD card drives MISO, monitors check MOSI frames and responses.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_spi_cmd_host;
  import sd_pkg::*;

  localparam int CLK_DIV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sd_clk, sd_cs_n, sd_mosi, sd_miso;

  sd_spi_cmd_host_if bus_if ();

  sd_spi_cmd_host #(.CLK_DIV(CLK_DIV), .NCR_MAX(8), .NRC_CLKS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_bus (bus_if),
    .sd_clk  (sd_clk),
    .sd_cs_n (sd_cs_n),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [39:0] data;
    logic        to;
    int          lat;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        rsp_q[$];
  logic [47:0] frm_q[$];
  int          acc_q[$];
  int          acc_cnt = 0, rsp_cnt = 0, last_acc_cyc = 0, last_rsp_cyc = 0;
  int          nbits = 0, tail_zero = 0;
  logic [47:0] fr = '0;

  // Card script: W idle ones after the frame, then an N-bit response MSB first.
  int          card_w = 0, card_n = 8, edge_n = 0;
  logic [39:0] card_resp = '0;
  logic        card_none = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int w, input int n);
    return (48 + w + n + 8) * 2 * CLK_DIV + 1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Card: count rising sd_clk edges in the current chip-select window.
  initial forever begin
    @(posedge sd_clk or posedge sd_cs_n);
    if (sd_cs_n) edge_n = 0;
    else edge_n++;
  end

  always_comb begin
    int k;
    int j;
    k = edge_n + 1 - 48;
    j = k - card_w - 1;
    sd_miso = 1'b1;
    if (!card_none && k > card_w && j < card_n) sd_miso = card_resp[card_n - 1 - j];
  end

  // MOSI monitor: first 48 bits of each window form the frame, everything after must be 1.
  initial forever begin
    logic [47:0] ef;
    @(posedge sd_clk or posedge sd_cs_n);
    if (sd_cs_n) nbits = 0;
    else if (nbits < 48) begin
      fr = {fr[46:0], sd_mosi};
      nbits++;
      if (nbits == 48) begin
        tail_zero = 0;
        if (frm_q.size() == 0) chk("frame_unexpected", 64'd1, 64'd0);
        else begin
          ef = frm_q.pop_front();
          chk("mosi_frame", 64'(fr), 64'(ef));
        end
      end
    end else if (!sd_mosi) tail_zero++;
  end

  // Response monitor and accept tracker.
  initial forever begin
    exp_t e;
    int   a;
    @(negedge clk);
    if (rst_n && bus_if.rsp_valid) begin
      last_rsp_cyc = cyc;
      rsp_cnt++;
      if (rsp_q.size() == 0 || acc_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = rsp_q.pop_front();
        a = acc_q.pop_front();
        chk("rsp_data", 64'(bus_if.rsp_data), 64'(e.data));
        chk("rsp_timeout", 64'(bus_if.rsp_timeout), 64'(e.to));
        chk("latency", 64'(cyc - a), 64'(e.lat));
        chk("mosi_tail_ones", 64'(tail_zero), 64'd0);
      end
    end
    if (rst_n && bus_if.cmd_valid && bus_if.cmd_ready) begin
      acc_q.push_back(cyc);
      acc_cnt++;
      last_acc_cyc = cyc;
    end
  end

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic lng);
    int n;
    n = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_idx   = idx;
    bus_if.cmd_arg   = arg;
    bus_if.resp_long = lng;
    while (!bus_if.cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_wait_expired", 64'd1, 64'd0);
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int r0);
    int n;
    n = 0;
    while (rsp_cnt <= r0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("rsp_wait_expired", 64'd1, 64'd0);
  endtask

  task automatic expect_rsp(input logic [47:0] ef, input int w, input int n,
                            input logic [39:0] d, input logic to);
    exp_t e;
    frm_q.push_back(ef);
    e.data = d;
    e.to   = to;
    e.lat  = lat_of(w, n);
    rsp_q.push_back(e);
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                      input logic [47:0] ef, input int w, input logic [39:0] resp, input logic none);
    int r0;
    card_w    = w;
    card_n    = lng ? 40 : 8;
    card_resp = resp;
    card_none = none;
    if (none) expect_rsp(ef, 64, 0, 40'hFF_FFFF_FFFF, 1'b1);
    else      expect_rsp(ef, w, card_n, resp, 1'b0);
    r0 = rsp_cnt;
    issue(idx, arg, lng);
    wait_rsp(r0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus_if.cmd_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(bus_if.rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(bus_if.rsp_data), 64'd0);
    chk({tag, "_rsp_timeout"}, 64'(bus_if.rsp_timeout), 64'd0);
    chk({tag, "_sd_clk"}, 64'(sd_clk), 64'd0);
    chk({tag, "_sd_cs_n"}, 64'(sd_cs_n), 64'd1);
    chk({tag, "_sd_mosi"}, 64'(sd_mosi), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, r0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_idx   = '0;
    bus_if.cmd_arg   = '0;
    bus_if.resp_long = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset");

    // CMD0, R1 0x01 after two idle bytes.
    send(CMD0, 32'h0, 1'b0, 48'h40_00_00_00_00_95, 16, 40'h01, 1'b0);
    // CMD8, R7 01 00 00 01 AA.
    send(CMD8, 32'h1AA, 1'b1, 48'h48_00_00_01_AA_87, 8, 40'h01_0000_01AA, 1'b0);

    // CMD55 then ACMD41 with cmd_valid held high across both.
    a0 = acc_cnt;
    r0 = rsp_cnt;
    card_w = 8; card_n = 8; card_resp = 40'h01; card_none = 1'b0;
    expect_rsp(48'h77_00_00_00_00_65, 8, 8, 40'h01, 1'b0);
    expect_rsp(48'h69_40_00_00_00_77, 8, 8, 40'h00, 1'b0);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_idx   = CMD55;
    bus_if.cmd_arg   = 32'h0;
    bus_if.resp_long = 1'b0;
    @(posedge clk); #1;
    bus_if.cmd_idx = ACMD41;
    bus_if.cmd_arg = 32'h4000_0000;
    chk("busy_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
    n = 0;
    while (!bus_if.rsp_valid && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("pair_rsp_wait_expired", 64'd1, 64'd0);
    chk("gap_sd_cs_n_high", 64'(sd_cs_n), 64'd1);
    chk("gap_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    card_resp = 40'h00;
    @(posedge clk); #1;
    chk("gap_sd_cs_n_low_again", 64'(sd_cs_n), 64'd0);
    chk("accepts_in_held_window", 64'(acc_cnt - a0), 64'd2);
    chk("accept_in_rsp_cycle", 64'(last_acc_cyc), 64'(last_rsp_cyc));
    bus_if.cmd_valid = 1'b0;
    wait_rsp(r0 + 1);

    // MISO stuck high: timeout after 64 wait edges, then values hold.
    send(CMD0, 32'h0, 1'b0, 48'h40_00_00_00_00_95, 0, 40'h0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_rsp_timeout", 64'(bus_if.rsp_timeout), 64'd1);
    chk("hold_rsp_data", 64'(bus_if.rsp_data), 64'hFF_FFFF_FFFF);

    // Start bit on the last allowed wait edge (64).
    send(CMD0, 32'h0, 1'b0, 48'h40_00_00_00_00_95, 63, 40'h01, 1'b0);

    // Reset in the middle of the frame; the aborted command expects nothing.
    issue(CMD8, 32'h1AA, 1'b1);
    n = 0;
    while (nbits < 20 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk("bit20_wait_expired", 64'd1, 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midsend_reset");
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(CMD0, 32'h0, 1'b0, 48'h40_00_00_00_00_95, 16, 40'h01, 1'b0);

    chk("scoreboard_drained", 64'(rsp_q.size() + frm_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
